// File: rtl/pll_lock_sequencer.sv
// ---------------------------------------------------------------------------
// pll_lock_sequencer : PLL reset/lock supervisor with ordered domain release
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pll_lock_sequencer #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 50000,
  parameter int STABLE_CYCLES = 1000,
  parameter int RELEASE_GAP   = 8,
  parameter int MAX_RETRY     = 3,
  parameter int N_DOMAINS     = 3
) (
  input  logic                 i_clk_50m,
  input  logic                 i_rst_n,
  input  logic                 i_pll_lock,
  input  logic                 i_force_reset,
  output logic                 o_pll_rst,
  output logic [N_DOMAINS-1:0] o_dom_rst_n,
  output logic                 o_ready,
  output logic                 o_fail,
  output logic [1:0]           o_retry_cnt,
  output logic [7:0]           o_loss_cnt,
  output logic [2:0]           o_state
);

  localparam logic [2:0] ST_PLLRST   = 3'd0;
  localparam logic [2:0] ST_WAITLOCK = 3'd1;
  localparam logic [2:0] ST_STABLE   = 3'd2;
  localparam logic [2:0] ST_RELEASE  = 3'd3;
  localparam logic [2:0] ST_RUN      = 3'd4;
  localparam logic [2:0] ST_FAIL     = 3'd5;

  // Timer must hold the largest terminal value reached in any state.
  localparam int MAX_A   = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_B   = (MAX_A > STABLE_CYCLES + 1) ? MAX_A : STABLE_CYCLES + 1;
  localparam int MAX_CNT = (MAX_B > RELEASE_GAP * N_DOMAINS) ? MAX_B : RELEASE_GAP * N_DOMAINS;
  localparam int TW      = $clog2(MAX_CNT + 1);

  localparam logic [TW-1:0] RST_LAST     = TW'(RST_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0] STABLE_LAST  = TW'(STABLE_CYCLES);
  localparam logic [TW-1:0] RUN_LAST     = TW'(RELEASE_GAP * N_DOMAINS - 1);
  localparam logic [1:0]    RETRY_MAX    = 2'(MAX_RETRY);

  logic [2:0]    state;
  logic [TW-1:0] timer;
  logic          lock_meta;
  logic          lock_s;
  logic          lost;

  assign lost    = !lock_s && ((state == ST_RELEASE) || (state == ST_RUN));
  assign o_state = state;

  always_ff @(posedge i_clk_50m or negedge i_rst_n) begin
    if (!i_rst_n) begin
      lock_meta   <= 1'b0;
      lock_s      <= 1'b0;
      state       <= ST_PLLRST;
      timer       <= '0;
      o_pll_rst   <= 1'b1;
      o_dom_rst_n <= '0;
      o_ready     <= 1'b0;
      o_fail      <= 1'b0;
      o_retry_cnt <= 2'd0;
      o_loss_cnt  <= 8'd0;
    end else begin
      lock_meta <= i_pll_lock;
      lock_s    <= lock_meta;
      if (i_force_reset) begin
        state       <= ST_PLLRST;
        timer       <= '0;
        o_pll_rst   <= 1'b1;
        o_dom_rst_n <= '0;
        o_ready     <= 1'b0;
        o_fail      <= 1'b0;
        o_retry_cnt <= 2'd0;
      end else if (lost) begin
        state       <= ST_PLLRST;
        timer       <= '0;
        o_pll_rst   <= 1'b1;
        o_dom_rst_n <= '0;
        o_ready     <= 1'b0;
        o_retry_cnt <= 2'd0;
        if (o_loss_cnt != 8'hFF) o_loss_cnt <= o_loss_cnt + 8'd1;
      end else begin
        case (state)
          ST_PLLRST: begin
            if (timer == RST_LAST) begin
              state     <= ST_WAITLOCK;
              timer     <= '0;
              o_pll_rst <= 1'b0;
            end else begin
              timer <= timer + 1'b1;
            end
          end
          ST_WAITLOCK: begin
            if (lock_s) begin
              state <= ST_STABLE;
              timer <= '0;
            end else if (timer == TIMEOUT_LAST) begin
              timer     <= '0;
              o_pll_rst <= 1'b1;
              if (o_retry_cnt == RETRY_MAX) begin
                state  <= ST_FAIL;
                o_fail <= 1'b1;
              end else begin
                state       <= ST_PLLRST;
                o_retry_cnt <= o_retry_cnt + 2'd1;
              end
            end else begin
              timer <= timer + 1'b1;
            end
          end
          ST_STABLE: begin
            if (!lock_s) begin
              state <= ST_WAITLOCK;
              timer <= '0;
            end else if (timer == STABLE_LAST) begin
              state          <= ST_RELEASE;
              timer          <= '0;
              o_dom_rst_n[0] <= 1'b1;
            end else begin
              timer <= timer + 1'b1;
            end
          end
          ST_RELEASE: begin
            // Bit k is set one cycle ahead so it is visible at timer == GAP*k.
            for (int k = 1; k < N_DOMAINS; k++) begin
              if (timer == TW'(RELEASE_GAP * k - 1)) o_dom_rst_n[k] <= 1'b1;
            end
            if (timer == RUN_LAST) begin
              state   <= ST_RUN;
              timer   <= '0;
              o_ready <= 1'b1;
            end else begin
              timer <= timer + 1'b1;
            end
          end
          ST_RUN: begin
            timer <= '0;
          end
          ST_FAIL: begin
            o_pll_rst   <= 1'b1;
            o_dom_rst_n <= '0;
            o_fail      <= 1'b1;
          end
          default: begin
            state       <= ST_PLLRST;
            timer       <= '0;
            o_pll_rst   <= 1'b1;
            o_dom_rst_n <= '0;
            o_ready     <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pll_lock_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pll_lock_sequencer : directed table + corner sequences for the sequencer
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_pll_lock_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pll_lock;
  logic       force_reset;
  logic       pll_rst;
  logic [2:0] dom_rst_n;
  logic       ready;
  logic       fail;
  logic [1:0] retry_cnt;
  logic [7:0] loss_cnt;
  logic [2:0] state;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pll_lock_sequencer #(
    .RST_CYCLES   (4),
    .LOCK_TIMEOUT (20),
    .STABLE_CYCLES(10),
    .RELEASE_GAP  (3),
    .MAX_RETRY    (2),
    .N_DOMAINS    (3)
  ) dut (
    .i_clk_50m    (clk),
    .i_rst_n      (rst_n),
    .i_pll_lock   (pll_lock),
    .i_force_reset(force_reset),
    .o_pll_rst    (pll_rst),
    .o_dom_rst_n  (dom_rst_n),
    .o_ready      (ready),
    .o_fail       (fail),
    .o_retry_cnt  (retry_cnt),
    .o_loss_cnt   (loss_cnt),
    .o_state      (state)
  );

  typedef struct {
    int         adv;
    logic       lock;
    logic [2:0] st;
    logic       pr;
    logic [2:0] dom;
    logic       rdy;
    logic       fl;
    logic [1:0] rt;
    logic [7:0] ls;
  } vec_t;

  localparam int NVEC = 25;
  vec_t tbl [NVEC];

  function automatic logic [19:0] pk(input logic [2:0] st, input logic pr, input logic [2:0] dom,
                                     input logic rdy, input logic fl, input logic [1:0] rt,
                                     input logic [7:0] ls);
    return {st, pr, dom, rdy, fl, rt, ls};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [19:0] exp);
    logic [19:0] obs;
    obs = {state, pll_rst, dom_rst_n, ready, fail, retry_cnt, loss_cnt};
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got st=%0d pr=%b dom=%b rdy=%b fail=%b rt=%0d loss=%0d exp st=%0d pr=%b dom=%b rdy=%b fail=%b rt=%0d loss=%0d",
               name, obs[19:17], obs[16], obs[15:13], obs[12], obs[11], obs[10:9], obs[7:0],
               exp[19:17], exp[16], exp[15:13], exp[12], exp[11], exp[10:9], exp[7:0]);
    end
  endtask

  initial begin
    // Edge numbers (eN) count rising edges after reset release.
    // Normal bring-up: lock applied after e9, STABLE at e12, bit0 e23, bit1 e26, bit2 e29, RUN e32.
    tbl[0]  = '{3,  1'b0, 3'd0, 1'b1, 3'b000, 1'b0, 1'b0, 2'd0, 8'd0};
    tbl[1]  = '{1,  1'b0, 3'd1, 1'b0, 3'b000, 1'b0, 1'b0, 2'd0, 8'd0};
    tbl[2]  = '{5,  1'b0, 3'd1, 1'b0, 3'b000, 1'b0, 1'b0, 2'd0, 8'd0};
    tbl[3]  = '{2,  1'b1, 3'd1, 1'b0, 3'b000, 1'b0, 1'b0, 2'd0, 8'd0};
    tbl[4]  = '{1,  1'b1, 3'd2, 1'b0, 3'b000, 1'b0, 1'b0, 2'd0, 8'd0};
    tbl[5]  = '{10, 1'b1, 3'd2, 1'b0, 3'b000, 1'b0, 1'b0, 2'd0, 8'd0};
    tbl[6]  = '{1,  1'b1, 3'd3, 1'b0, 3'b001, 1'b0, 1'b0, 2'd0, 8'd0};
    tbl[7]  = '{2,  1'b1, 3'd3, 1'b0, 3'b001, 1'b0, 1'b0, 2'd0, 8'd0};
    tbl[8]  = '{1,  1'b1, 3'd3, 1'b0, 3'b011, 1'b0, 1'b0, 2'd0, 8'd0};
    tbl[9]  = '{3,  1'b1, 3'd3, 1'b0, 3'b111, 1'b0, 1'b0, 2'd0, 8'd0};
    tbl[10] = '{2,  1'b1, 3'd3, 1'b0, 3'b111, 1'b0, 1'b0, 2'd0, 8'd0};
    tbl[11] = '{1,  1'b1, 3'd4, 1'b0, 3'b111, 1'b1, 1'b0, 2'd0, 8'd0};
    // Lock loss in RUN (dropped after e32), then lock absent: timeouts at e59, e83, FAIL at e107.
    tbl[12] = '{2,  1'b0, 3'd4, 1'b0, 3'b111, 1'b1, 1'b0, 2'd0, 8'd0};
    tbl[13] = '{1,  1'b0, 3'd0, 1'b1, 3'b000, 1'b0, 1'b0, 2'd0, 8'd1};
    tbl[14] = '{3,  1'b0, 3'd0, 1'b1, 3'b000, 1'b0, 1'b0, 2'd0, 8'd1};
    tbl[15] = '{1,  1'b0, 3'd1, 1'b0, 3'b000, 1'b0, 1'b0, 2'd0, 8'd1};
    tbl[16] = '{19, 1'b0, 3'd1, 1'b0, 3'b000, 1'b0, 1'b0, 2'd0, 8'd1};
    tbl[17] = '{1,  1'b0, 3'd0, 1'b1, 3'b000, 1'b0, 1'b0, 2'd1, 8'd1};
    tbl[18] = '{3,  1'b0, 3'd0, 1'b1, 3'b000, 1'b0, 1'b0, 2'd1, 8'd1};
    tbl[19] = '{1,  1'b0, 3'd1, 1'b0, 3'b000, 1'b0, 1'b0, 2'd1, 8'd1};
    tbl[20] = '{20, 1'b0, 3'd0, 1'b1, 3'b000, 1'b0, 1'b0, 2'd2, 8'd1};
    tbl[21] = '{4,  1'b0, 3'd1, 1'b0, 3'b000, 1'b0, 1'b0, 2'd2, 8'd1};
    tbl[22] = '{19, 1'b0, 3'd1, 1'b0, 3'b000, 1'b0, 1'b0, 2'd2, 8'd1};
    tbl[23] = '{1,  1'b0, 3'd5, 1'b1, 3'b000, 1'b0, 1'b1, 2'd2, 8'd1};
    tbl[24] = '{5,  1'b0, 3'd5, 1'b1, 3'b000, 1'b0, 1'b1, 2'd2, 8'd1};

    rst_n       = 1'b0;
    pll_lock    = 1'b0;
    force_reset = 1'b0;
    tick(2);
    check("reset_state", pk(3'd0, 1'b1, 3'b000, 1'b0, 1'b0, 2'd0, 8'd0));
    rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      pll_lock = tbl[i].lock;
      tick(tbl[i].adv);
      check($sformatf("vec%0d", i),
            pk(tbl[i].st, tbl[i].pr, tbl[i].dom, tbl[i].rdy, tbl[i].fl, tbl[i].rt, tbl[i].ls));
    end

    // Force out of FAIL with lock present (now at e112): PLLRST e113, STABLE e118, RELEASE e129, RUN e138.
    pll_lock    = 1'b1;
    force_reset = 1'b1;
    tick(1);
    force_reset = 1'b0;
    check("force_from_fail", pk(3'd0, 1'b1, 3'b000, 1'b0, 1'b0, 2'd0, 8'd1));
    tick(24);
    check("force_release_pre_run", pk(3'd3, 1'b0, 3'b111, 1'b0, 1'b0, 2'd0, 8'd1));
    tick(1);
    check("force_reaches_run", pk(3'd4, 1'b0, 3'b111, 1'b1, 1'b0, 2'd0, 8'd1));

    // Force from RUN keeps loss count; STABLE at e144, glitch applied after e148.
    force_reset = 1'b1;
    tick(1);
    force_reset = 1'b0;
    check("force_from_run", pk(3'd0, 1'b1, 3'b000, 1'b0, 1'b0, 2'd0, 8'd1));
    tick(9);
    check("stable_before_glitch", pk(3'd2, 1'b0, 3'b000, 1'b0, 1'b0, 2'd0, 8'd1));
    pll_lock = 1'b0;
    tick(1);
    pll_lock = 1'b1;
    tick(1);
    check("glitch_still_stable", pk(3'd2, 1'b0, 3'b000, 1'b0, 1'b0, 2'd0, 8'd1));
    tick(1);
    check("glitch_to_waitlock", pk(3'd1, 1'b0, 3'b000, 1'b0, 1'b0, 2'd0, 8'd1));
    tick(1);
    check("relock_stable", pk(3'd2, 1'b0, 3'b000, 1'b0, 1'b0, 2'd0, 8'd1));
    tick(10);
    check("relock_not_yet_released", pk(3'd2, 1'b0, 3'b000, 1'b0, 1'b0, 2'd0, 8'd1));
    tick(1);
    check("relock_bit0_released", pk(3'd3, 1'b0, 3'b001, 1'b0, 1'b0, 2'd0, 8'd1));

    // Asynchronous reset mid-RELEASE, sampled before the next clock edge.
    rst_n = 1'b0;
    #1;
    check("async_reset_mid_release", pk(3'd0, 1'b1, 3'b000, 1'b0, 1'b0, 2'd0, 8'd0));
    tick(2);
    check("reset_held", pk(3'd0, 1'b1, 3'b000, 1'b0, 1'b0, 2'd0, 8'd0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
